// File: rtl/system.sv
// system: serial MSB-first 3-bit magnitude comparator with parallel cross-check.
//
// One comparison symbol {y, z} arrives per clock, scanning from bit 2 down
// to bit 0:
//   01 = bits equal, 10 = A bit > B bit, 11 = B bit > A bit, 00 = idle.
// The verdict is kept in a 3-state FSM. The first differing bit of a word
// decides the verdict. Every third valid symbol closes the word. On that
// cycle the serial verdict is compared with a direct compare of A and B.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (release synchronised here)
//   A, B      in   [2:0] parallel words, stable for the whole word
//   y, z      in   serial comparison symbol
//   f         out  registered, verdict A > B
//   eq        out  registered, verdict "equal so far"
//   lt        out  registered, verdict A < B
//   done      out  registered, 1-cycle pulse when a word's 3rd symbol is absorbed
//   mismatch  out  registered, serial/parallel disagreement at the last word end
module system (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       y,
    input  logic       z,
    output logic       f,
    output logic       eq,
    output logic       lt,
    output logic       done,
    output logic       mismatch
);

    typedef enum logic [1:0] {
        ST_EQ  = 2'd0,
        ST_AGT = 2'd1,
        ST_BGT = 2'd2
    } state_t;

    // Reset asserts immediately but releases only after two clock edges.
    logic sync1_q, sync2_q;
    logic rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync2_q <= sync1_q;
        end
    end

    assign rst_int_n = sync2_q;

    state_t     state_q, state_d;
    state_t     base_state;
    state_t     par_state;
    logic [1:0] cnt_q, cnt_d;
    logic       f_q, eq_q, lt_q, done_q, mismatch_q;
    logic       done_d, mismatch_d;
    logic       valid;

    always_comb begin
        valid      = y | z;
        // The first symbol of a word starts from EQ. This discards the
        // verdict left over from the previous word.
        base_state = (cnt_q == 2'd0) ? ST_EQ : state_q;
        if (A > B) begin
            par_state = ST_AGT;
        end else if (A == B) begin
            par_state = ST_EQ;
        end else begin
            par_state = ST_BGT;
        end

        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;

        if (valid) begin
            state_d = base_state;
            if (base_state == ST_EQ) begin
                case ({y, z})
                    2'b10:   state_d = ST_AGT;
                    2'b11:   state_d = ST_BGT;
                    default: state_d = ST_EQ;
                endcase
            end
            if (cnt_q == 2'd2) begin
                cnt_d      = 2'd0;
                done_d     = 1'b1;
                mismatch_d = (state_d != par_state);
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_EQ;
            cnt_q      <= 2'd0;
            f_q        <= 1'b0;
            eq_q       <= 1'b1;
            lt_q       <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f_q        <= (state_d == ST_AGT);
            eq_q       <= (state_d == ST_EQ);
            lt_q       <= (state_d == ST_BGT);
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign f        = f_q;
    assign eq       = eq_q;
    assign lt       = lt_q;
    assign done     = done_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_system.sv
module tb_system;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] A = 3'd0;
    logic [2:0] B = 3'd0;
    logic       y = 1'b0;
    logic       z = 1'b0;
    logic       f, eq, lt, done, mismatch;

    system dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .y        (y),
        .z        (z),
        .f        (f),
        .eq       (eq),
        .lt       (lt),
        .done     (done),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model. The verdict is 0 (equal), 1 (A>B) or 2 (A<B).
    // Symbols of the current word are kept in a queue. The verdict is the
    // first non-equal symbol found in that queue.
    logic [1:0] word_q[$];
    int         m_verdict = 0;
    logic       m_done = 1'b0;
    logic       m_mm = 1'b0;
    int         hold = 0;

    function automatic int sym_verdict(input logic [1:0] s);
        return (s == 2'b10) ? 1 : (s == 2'b11) ? 2 : 0;
    endfunction

    function automatic int word_cmp(input logic [2:0] a, input logic [2:0] b);
        if (int'(a) > int'(b)) return 1;
        if (int'(a) == int'(b)) return 0;
        return 2;
    endfunction

    task automatic model_step(input logic [1:0] s);
        int v;
        m_done = 1'b0;
        if (hold > 0) begin
            hold--;
            return;
        end
        if (s == 2'b00) return;
        word_q.push_back(s);
        v = 0;
        foreach (word_q[i]) begin
            if (v == 0) v = sym_verdict(word_q[i]);
        end
        m_verdict = v;
        if (word_q.size() == 3) begin
            m_done = 1'b1;
            m_mm   = (m_verdict != word_cmp(A, B));
            word_q.delete();
        end
    endtask

    task automatic check(input string name);
        logic [4:0] act, exp;
        act = {f, eq, lt, done, mismatch};
        exp = {m_verdict == 1, m_verdict == 0, m_verdict == 2, m_done, m_mm};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s t=%0t {f,eq,lt,done,mm} got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] s, input string name);
        @(negedge clk);
        {y, z} = s;
        @(posedge clk);
        #1;
        model_step(s);
        check(name);
    endtask

    // Called just after a check (posedge+1). Asserts reset, checks the
    // immediate effect, then releases rst_n so that the next two edges are
    // swallowed by the release synchroniser.
    task automatic do_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        word_q.delete();
        m_verdict = 0;
        m_done    = 1'b0;
        m_mm      = 1'b0;
        hold      = 0;
        check(name);
        apply(2'b00, name);
        apply(2'b00, name);
        rst_n = 1'b1;
        hold  = 2;
    endtask

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] s0, s1, s2;
        int         gap;
        logic [3:0] exp;  // {f, eq, lt, mismatch} at done
    } vec_t;

    vec_t tbl[7];

    task automatic check_word(input int k);
        logic [4:0] act, exp;
        act = {f, eq, lt, mismatch, done};
        exp = {tbl[k].exp, 1'b1};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL table[%0d] {f,eq,lt,mm,done} got %b want %b", k, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{3'b111, 3'b101, 2'b01, 2'b10, 2'b01, 0, 4'b1000};
        tbl[1] = '{3'b010, 3'b110, 2'b11, 2'b01, 2'b10, 0, 4'b0010};
        tbl[2] = '{3'b101, 3'b101, 2'b01, 2'b01, 2'b01, 2, 4'b0100};
        tbl[3] = '{3'b001, 3'b100, 2'b10, 2'b01, 2'b01, 0, 4'b1001};
        tbl[4] = '{3'b011, 3'b011, 2'b01, 2'b01, 2'b01, 1, 4'b0100};
        tbl[5] = '{3'b100, 3'b000, 2'b10, 2'b01, 2'b01, 0, 4'b1000};
        tbl[6] = '{3'b001, 3'b011, 2'b01, 2'b11, 2'b01, 0, 4'b0010};

        // Reset with the clock running, then idle.
        #12;
        do_reset("reset");
        for (int i = 0; i < 5; i++) apply(2'b00, "idle_after_reset");

        // Directed words; the last two run back-to-back.
        for (int k = 0; k < 7; k++) begin
            logic [1:0] ss[3];
            ss[0] = tbl[k].s0;
            ss[1] = tbl[k].s1;
            ss[2] = tbl[k].s2;
            A = tbl[k].a;
            B = tbl[k].b;
            for (int j = 0; j < 3; j++) begin
                if (j > 0) begin
                    for (int g = 0; g < tbl[k].gap; g++) apply(2'b00, "table_gap");
                end
                apply(ss[j], "table_sym");
            end
            check_word(k);
        end
        apply(2'b00, "done_falls");

        // Reset after the 2nd symbol of a word: partial verdict discarded.
        A = 3'b000;
        B = 3'b001;
        apply(2'b10, "pre_reset_sym");
        apply(2'b01, "pre_reset_sym");
        do_reset("reset_midword");
        // Symbols on the two release edges are ignored.
        apply(2'b10, "release_edge");
        apply(2'b11, "release_edge");
        apply(2'b01, "post_reset");
        apply(2'b01, "post_reset");
        apply(2'b11, "post_reset");
        apply(2'b00, "post_reset");

        // Randomised words, mostly consistent with A/B, with idles and
        // occasional mid-word resets.
        for (int w = 0; w < 150; w++) begin
            logic       bad;
            logic [1:0] s;
            A   = 3'($urandom);
            B   = 3'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            for (int i = 2; i >= 0; i--) begin
                if (bad) s = 2'($urandom_range(1, 3));
                else if (A[i] == B[i]) s = 2'b01;
                else s = A[i] ? 2'b10 : 2'b11;
                while ($urandom_range(0, 3) == 0) apply(2'b00, "rand_idle");
                apply(s, "rand_sym");
                if (i == 1 && $urandom_range(0, 24) == 0) begin
                    do_reset("rand_reset");
                    apply(2'b00, "rand_release");
                    apply(2'b00, "rand_release");
                    break;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
